pipe_stall_ctrl: RTL
====================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges load-use hazards,
//  multi-cycle MUL/DIV occupancy, data-memory wait states and EX-stage branch redirects.
//  Drives per-stage register enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM
//  and MEM/WB. Keeps a stall-cycle performance counter and an MDU watchdog flag.
// PARAMETERS
//  CNT_W        32   width of stall_cycles counter (saturating)
//  MDU_TIMEOUT  64   max cycles in MDU_BUSY before watchdog fires (>=2)
// PORTS
//  clk           in   1      single clock; all state updates on rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  ex_mem_read   in   1      instruction in EX is a load
//  ex_rd         in   5      destination register of EX instruction
//  id_rs1        in   5      source 1 of ID instruction
//  id_rs2        in   5      source 2 of ID instruction
//  mdu_start     in   1      MUL/DIV entering EX this cycle
//  mdu_done      in   1      MDU result valid (1-cycle pulse)
//  dmem_req      in   1      MEM stage access active
//  dmem_ready    in   1      data memory completes access this cycle
//  branch_taken  in   1      EX resolves taken branch/jump (redirect)
//  pc_en         out  1      PC write enable
//  if_id_en      out  1      IF/ID write enable
//  id_ex_en      out  1      ID/EX write enable
//  ex_mem_en     out  1      EX/MEM write enable
//  mem_wb_en     out  1      MEM/WB write enable
//  if_id_flush   out  1      load NOP into IF/ID
//  id_ex_bubble  out  1      zero ID/EX control fields
//  ex_mem_bubble out  1      zero EX/MEM control fields
//  mem_wb_bubble out  1      zero MEM/WB control fields
//  stall_cycles  out  CNT_W  count of cycles with pc_en==0
//  mdu_timeout   out  1      sticky watchdog error
// BEHAVIOUR
//  States: RUN, MDU_BUSY, MEM_WAIT; 1-bit ret_state records RUN/MDU_BUSY for exit from MEM_WAIT.
//  Outputs are combinational from state+inputs. While rst_n=0: state=RUN, all *_en=0, all
//   bubbles/flush=1, stall_cycles=0, mdu_timeout=0, watchdog count=0.
//  Priority per cycle: MEM stall > MDU busy > branch redirect > load-use > normal.
//  mem_stall = dmem_req & ~dmem_ready (any state): all *_en=0, mem_wb_bubble=1; enter/stay MEM_WAIT;
//   on entry from RUN with mdu_start=1, ret_state=MDU_BUSY. mdu_done seen in MEM_WAIT sets
//   done_pend. Exit when dmem_ready=1: to ret_state, or RUN if done_pend; clear done_pend.
//  MDU_BUSY (or RUN with mdu_start & ~mdu_done): pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1,
//   mem_wb_en=1. mdu_done -> RUN (stages enabled that same cycle). mdu_start&mdu_done same
//   cycle in RUN: no stall.
//  Watchdog: counts cycles in MDU_BUSY; at MDU_TIMEOUT, set mdu_timeout, force RUN.
//   Count clears on leaving MDU_BUSY.
//  Branch (RUN, no mem/MDU stall): pc_en=1, if_id_flush=1, id_ex_bubble=1; overrides load-use.
//  Load-use: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2): pc_en=if_id_en=0,
//   id_ex_bubble=1, others enabled; exactly 1 cycle (EX advances).
//  Normal: all *_en=1, all bubbles/flush=0.
//  stall_cycles += 1 each cycle with pc_en==0 (not in reset); saturates at all-ones.
//  Async reset mid-stall returns to RUN immediately; pending done and ret_state cleared.
// STRUCTURE
//  pipe_ctrl_pkg: state enum (RUN/MDU_BUSY/MEM_WAIT), REG_X0=5'd0, REG_IDX_W=5.
//  Sub-module load_use_detect (combinational hazard compare, ex_rd!=0 guard). FSM, watchdog
//  and counter stay in this module.
// TESTING
//  ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle pc_en=if_id_en=0, id_ex_bubble=1; stall_cycles=1.
//  ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall; all enables 1.
//  mdu_start at t0, mdu_done at t0+4 -> pc_en=0 cycles t0..t0+3, ex_mem_bubble=1; RUN at t0+5.
//  In MDU_BUSY, dmem_req=1, dmem_ready=0 3 cycles, mdu_done pulses mid-wait -> all en=0;
//   after ready, RUN, not MDU_BUSY.
//  branch_taken=1 with load-use hazard -> pc_en=1, if_id_flush=1, id_ex_bubble=1, no stall.
//  MDU_TIMEOUT=8, mdu_start, no mdu_done -> mdu_timeout=1 after 8 cycles, state RUN;
//   rst_n pulse clears it.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// The stage_ctrl_t field order is also the bit order of the packed control word.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic mem_wb_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b1, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b1, mem_wb_bubble: 1'b1};

  localparam stage_ctrl_t CTRL_NORMAL = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_bubble: 1'b0, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b0};

  // Whole pipe frozen; MEM/WB receives a bubble so WB does not retire twice.
  localparam stage_ctrl_t CTRL_MEM_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
    if_id_flush: 1'b0, id_ex_bubble: 1'b0, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b1};

  localparam stage_ctrl_t CTRL_MDU_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_bubble: 1'b0, ex_mem_bubble: 1'b1, mem_wb_bubble: 1'b0};

  localparam stage_ctrl_t CTRL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b1, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b0};

  localparam stage_ctrl_t CTRL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b0, mem_wb_bubble: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
// x0 is never a real producer, so a load targeting it never stalls.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  output logic                 hazard
);

  assign hazard = ex_mem_read && (ex_rd != REG_X0) &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges memory waits, MDU occupancy, branch redirects
// and load-use hazards into per-stage enables and bubbles, plus stall counter and MDU watchdog.
//
// state       | meaning
// ST_RUN      | pipeline flowing; branch / load-use / MDU start evaluated
// ST_MDU_BUSY | MUL/DIV occupying EX; front end held, watchdog running
// ST_MEM_WAIT | data memory wait state; whole pipe frozen, ret_mdu_q says where to resume
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MDU_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 mdu_start,
  input  logic                 mdu_done,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 ex_mem_bubble,
  output logic                 mem_wb_bubble,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic                 mdu_timeout
);

  localparam int WD_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(MDU_TIMEOUT - 1);

  ctrl_state_t      state_q, state_d, eff_state;
  logic             ret_mdu_q, ret_mdu_d;
  logic             done_pend_q, done_pend_d;
  logic             enter_ret_mdu;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use, mem_stall, mdu_active;
  stage_ctrl_t      ctrl;

  load_use_detect u_load_use (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (load_use)
  );

  // The cycle that leaves MEM_WAIT behaves like the state being resumed.
  always_comb begin
    mem_stall = dmem_req & ~dmem_ready;
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (ret_mdu_q && !done_pend_q) ? ST_MDU_BUSY : ST_RUN;
    end
    mdu_active = ~mdu_done &
                 ((eff_state == ST_MDU_BUSY) | ((eff_state == ST_RUN) & mdu_start));
    enter_ret_mdu = (state_q == ST_MDU_BUSY) | mdu_start;
  end

  always_comb begin
    state_d     = state_q;
    ret_mdu_d   = ret_mdu_q;
    done_pend_d = done_pend_q;
    wd_cnt_d    = '0;
    timeout_d   = timeout_q;
    ctrl        = CTRL_NORMAL;

    if (mem_stall) begin
      ctrl    = CTRL_MEM_STALL;
      state_d = ST_MEM_WAIT;
      if (state_q == ST_MEM_WAIT) begin
        done_pend_d = done_pend_q | mdu_done;
      end else begin
        // A done arriving on the entry cycle must not be lost while frozen.
        ret_mdu_d   = enter_ret_mdu;
        done_pend_d = enter_ret_mdu & mdu_done;
      end
    end else begin
      state_d     = ST_RUN;
      ret_mdu_d   = 1'b0;
      done_pend_d = 1'b0;
      if (mdu_active) begin
        ctrl = CTRL_MDU_STALL;
        if ((state_q == ST_MDU_BUSY) && (wd_cnt_q == '0)) begin
          timeout_d = 1'b1;
        end else begin
          state_d  = ST_MDU_BUSY;
          wd_cnt_d = (state_q == ST_MDU_BUSY) ? (wd_cnt_q - WD_W'(1)) : WD_LOAD;
        end
      end else if (branch_taken) begin
        ctrl = CTRL_BRANCH;
      end else if (load_use) begin
        ctrl = CTRL_LOAD_USE;
      end
    end

    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      ret_mdu_q   <= 1'b0;
      done_pend_q <= 1'b0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_mdu_q   <= ret_mdu_d;
      done_pend_q <= done_pend_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
      if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign if_id_en      = ctrl.if_id_en;
  assign id_ex_en      = ctrl.id_ex_en;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign stall_cycles  = stall_cnt_q;
  assign mdu_timeout   = timeout_q;

endmodule
